// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_PLL_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR,
    CAUSE_LOCK_LOSS,
    CAUSE_LOCK_TIMEOUT,
    CAUSE_SOFT
  } cause_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser, parametrised width, async active-high reset to 0.
// Latency 2 clk; no backpressure.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// PLL hold, lock qualification and ordered release of NUM_DOMAINS resets; re-sequences on
// lock loss or soft request. RST_SEQ_DEBOUNCE_EN: sw_reset_req is a raw button level, debounced.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int PLL_HOLD_CYCLES     = 127,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int NUM_DOMAINS         = 3,
  parameter int DOMAIN_GAP_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES     = 65536
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic                   pll_areset,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   seq_done,
  output logic [1:0]             reset_cause,
  output logic [7:0]             lock_retries
);

  localparam int CW = $clog2(max3(PLL_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, DOMAIN_GAP_CYCLES) + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_HELD  = '1;
  localparam logic [NUM_DOMAINS-1:0] FIRST_OUT = ALL_HELD << 1;

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || DOMAIN_GAP_CYCLES < 1 || DEBOUNCE_CYCLES < 1)
  begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic          lock_sync;
  logic          soft_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (areset),
    .d   (pll_locked),
    .q   (lock_sync)
  );

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          sw_sync;
  logic [DW-1:0] dcnt;
  logic          fired;

  sync_2ff #(.WIDTH(1)) u_sw_sync (
    .clk (clk),
    .rst (areset),
    .d   (sw_reset_req),
    .q   (sw_sync)
  );

  // One qualified pulse per press; the button must be released before it re-arms.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      dcnt   <= '0;
      fired  <= 1'b0;
      soft_q <= 1'b0;
    end else begin
      soft_q <= 1'b0;
      if (!sw_sync) begin
        dcnt  <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          soft_q <= 1'b1;
          fired  <= 1'b1;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end
`else
  assign soft_q = sw_reset_req;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= S_PLL_HOLD;
      cnt          <= '0;
      scnt         <= '0;
      pll_areset   <= 1'b1;
      domain_reset <= ALL_HELD;
      seq_done     <= 1'b0;
      reset_cause  <= CAUSE_POR;
      lock_retries <= 8'd0;
    end else begin
      case (state)
        S_PLL_HOLD: begin
          if (cnt == CW'(PLL_HOLD_CYCLES - 1)) begin
            pll_areset <= 1'b0;
            cnt        <= '0;
            scnt       <= '0;
            state      <= S_WAIT_LOCK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            reset_cause <= CAUSE_LOCK_TIMEOUT;
            if (lock_retries != 8'hFF) lock_retries <= lock_retries + 8'd1;
            pll_areset  <= 1'b1;
            cnt         <= '0;
            state       <= S_PLL_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
            if (!lock_sync) begin
              scnt <= '0;
            end else if (scnt == SW'(LOCK_STABLE_CYCLES - 1)) begin
              domain_reset <= FIRST_OUT;
              cnt          <= '0;
              state        <= S_RELEASE;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_sync) begin
            domain_reset <= ALL_HELD;
            seq_done     <= 1'b0;
            pll_areset   <= 1'b1;
            reset_cause  <= CAUSE_LOCK_LOSS;
            cnt          <= '0;
            state        <= S_PLL_HOLD;
          end else if (soft_q) begin
            domain_reset <= ALL_HELD;
            seq_done     <= 1'b0;
            reset_cause  <= CAUSE_SOFT;
            cnt          <= '0;
            state        <= S_RELEASE;
          end else if (state == S_RELEASE) begin
            // Shifting left releases the lowest still-held domain, preserving index order.
            if (cnt == CW'(DOMAIN_GAP_CYCLES - 1)) begin
              cnt <= '0;
              if (domain_reset != '0) begin
                domain_reset <= domain_reset << 1;
              end else begin
                seq_done <= 1'b1;
                state    <= S_RUN;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_PLL_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed table-driven bench for reset_sequencer; edges are counted from areset release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_areset;
  logic [2:0] domain_reset;
  logic       seq_done;
  logic [1:0] reset_cause;
  logic [7:0] lock_retries;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int LAST_K = 251;
`else
  localparam int LAST_K = 100000;
`endif

  reset_sequencer #(
    .PLL_HOLD_CYCLES     (127),
    .LOCK_STABLE_CYCLES  (64),
    .LOCK_TIMEOUT_CYCLES (4096),
    .NUM_DOMAINS         (3),
    .DOMAIN_GAP_CYCLES   (16),
    .DEBOUNCE_CYCLES     (32)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .pll_areset   (pll_areset),
    .domain_reset (domain_reset),
    .seq_done     (seq_done),
    .reset_cause  (reset_cause),
    .lock_retries (lock_retries)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic       pll;
    logic [2:0] dr;
    logic       done;
    logic [1:0] cause;
    logic       lock;
    logic       sw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Advance to 1 ns after the k-th rising edge since areset release.
  task automatic go(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic add(input int k, input logic pll, input logic [2:0] dr, input logic done,
                     input logic [1:0] cause, input logic lock, input logic sw);
    vec_t v;
    v.k = k; v.pll = pll; v.dr = dr; v.done = done; v.cause = cause; v.lock = lock; v.sw = sw;
    vecs.push_back(v);
  endtask

  initial begin
    // POR with lock 10 clks after pll_areset falls, then soft pulse, lock loss, combined event.
    add(126, 1, 3'b111, 0, 0, 0, 0);
    add(127, 0, 3'b111, 0, 0, 0, 0);
    add(137, 0, 3'b111, 0, 0, 1, 0);
    add(202, 0, 3'b111, 0, 0, 1, 0);
    add(203, 0, 3'b110, 0, 0, 1, 0);
    add(218, 0, 3'b110, 0, 0, 1, 0);
    add(219, 0, 3'b100, 0, 0, 1, 0);
    add(234, 0, 3'b100, 0, 0, 1, 0);
    add(235, 0, 3'b000, 0, 0, 1, 0);
    add(250, 0, 3'b000, 0, 0, 1, 0);
    add(251, 0, 3'b000, 1, 0, 1, 0);
    add(260, 0, 3'b000, 1, 0, 1, 1);
    add(261, 0, 3'b111, 0, 3, 1, 0);
    add(276, 0, 3'b111, 0, 3, 1, 0);
    add(277, 0, 3'b110, 0, 3, 1, 0);
    add(293, 0, 3'b100, 0, 3, 1, 0);
    add(309, 0, 3'b000, 0, 3, 1, 0);
    add(324, 0, 3'b000, 0, 3, 1, 0);
    add(325, 0, 3'b000, 1, 3, 1, 0);
    add(330, 0, 3'b000, 1, 3, 0, 0);
    add(332, 0, 3'b000, 1, 3, 0, 0);
    add(333, 1, 3'b111, 0, 1, 0, 0);
    add(335, 1, 3'b111, 0, 1, 1, 0);
    add(459, 1, 3'b111, 0, 1, 1, 0);
    add(460, 0, 3'b111, 0, 1, 1, 0);
    add(523, 0, 3'b111, 0, 1, 1, 0);
    add(524, 0, 3'b110, 0, 1, 1, 0);
    add(540, 0, 3'b100, 0, 1, 1, 0);
    add(556, 0, 3'b000, 0, 1, 1, 0);
    add(572, 0, 3'b000, 1, 1, 1, 0);
    add(580, 0, 3'b000, 1, 1, 0, 0);
    add(582, 0, 3'b000, 1, 1, 0, 1);
    add(583, 1, 3'b111, 0, 1, 0, 0);
    add(585, 1, 3'b111, 0, 1, 1, 0);
    add(709, 1, 3'b111, 0, 1, 1, 0);
    add(710, 0, 3'b111, 0, 1, 1, 0);
    add(773, 0, 3'b111, 0, 1, 1, 0);
    add(774, 0, 3'b110, 0, 1, 1, 0);
    add(822, 0, 3'b000, 1, 1, 1, 0);

    // Reset state while areset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pll", int'(pll_areset), 1);
    chk("rst_dr", int'(domain_reset), 7);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_cause", int'(reset_cause), 0);
    chk("rst_retries", int'(lock_retries), 0);
    #2 areset = 1'b0;
    edge_n = 0;

    // Lock never asserts: PLL reset retried every 127+4096 edges.
    go(126);   chk("to_pll_hold", int'(pll_areset), 1);
    go(127);   chk("to_pll_fall", int'(pll_areset), 0);
    go(4222);  chk("to_pll_wait", int'(pll_areset), 0);
    chk("to_retries0", int'(lock_retries), 0);
    go(4223);  chk("to_pll_rise", int'(pll_areset), 1);
    chk("to_cause", int'(reset_cause), 2);
    chk("to_retries1", int'(lock_retries), 1);
    go(12668); chk("to_retries2", int'(lock_retries), 2);
    go(12669); chk("to_retries3", int'(lock_retries), 3);
    chk("to_pll_rise3", int'(pll_areset), 1);

    // Lock arrives during the hold; release proceeds, then areset hits mid-release.
    go(12700); pll_locked = 1'b1;
    go(12859); chk("tr_dr_held", int'(domain_reset), 7);
    go(12860); chk("tr_dr_first", int'(domain_reset), 6);
    go(12880); chk("tr_dr_second", int'(domain_reset), 4);
    chk("tr_cause", int'(reset_cause), 2);
    chk("tr_retries", int'(lock_retries), 3);
    pll_locked = 1'b0;
    areset = 1'b1;
    #1;
    chk("ar_pll", int'(pll_areset), 1);
    chk("ar_dr", int'(domain_reset), 7);
    chk("ar_done", int'(seq_done), 0);
    chk("ar_cause", int'(reset_cause), 0);
    chk("ar_retries", int'(lock_retries), 0);
    #2 areset = 1'b0;
    edge_n = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].k > LAST_K) break;
      go(vecs[i].k);
      chk($sformatf("v%0d_pll", vecs[i].k), int'(pll_areset), int'(vecs[i].pll));
      chk($sformatf("v%0d_dr", vecs[i].k), int'(domain_reset), int'(vecs[i].dr));
      chk($sformatf("v%0d_done", vecs[i].k), int'(seq_done), int'(vecs[i].done));
      chk($sformatf("v%0d_cause", vecs[i].k), int'(reset_cause), int'(vecs[i].cause));
      pll_locked   = vecs[i].lock;
      sw_reset_req = vecs[i].sw;
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    // Bounces shorter than 32 clks do nothing; a 40-clk hold acts exactly once.
    go(260); sw_reset_req = 1'b1;
    go(270); sw_reset_req = 1'b0;
    go(273); sw_reset_req = 1'b1;
    go(293); sw_reset_req = 1'b0;
    go(300);
    chk("db_bounce_dr", int'(domain_reset), 0);
    chk("db_bounce_done", int'(seq_done), 1);
    sw_reset_req = 1'b1;
    go(334); chk("db_pre_dr", int'(domain_reset), 0);
    go(335); chk("db_hit_dr", int'(domain_reset), 7);
    chk("db_hit_cause", int'(reset_cause), 3);
    chk("db_hit_pll", int'(pll_areset), 0);
    go(340); sw_reset_req = 1'b0;
    go(351); chk("db_rel0", int'(domain_reset), 6);
    go(399); chk("db_done", int'(seq_done), 1);
    go(420);
    chk("db_once_dr", int'(domain_reset), 0);
    chk("db_once_done", int'(seq_done), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
